// File: rtl/ser_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
// Shared definitions for the w_serializer front end: the serializer state
// encoding, the default word length and a helper that sizes the bit counter.
// Optional feature macro used by the design: SER_PARITY_EN (adds the parity
// state and the trailing even-parity bit).
// ---------------------------------------------------------------------------
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;

    // Bit counter only needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice;
    // the floor of 1 keeps the vector legal for degenerate widths.
    function automatic int ser_cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// ---------------------------------------------------------------------------
// ser_bit_counter
// Loadable up-counter that tracks which bit of the current word is on the
// serial line. It saturates at WIDTH-1 and never wraps.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset, clears the count to 0
//   clear  - synchronous clear to 0 (start of a new word), wins over inc
//   inc    - advance by one, ignored once WIDTH-1 is reached
//   term   - high while the count equals WIDTH-1 (last data bit)
// ---------------------------------------------------------------------------
module ser_bit_counter
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic term
);

    localparam int             CW   = ser_cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    // Clear has priority so a word accepted on its predecessor's last bit
    // restarts at 0; saturating at LAST keeps the counter parked there while
    // the parity bit (if any) is on the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == LAST);

endmodule

// File: rtl/w_serializer.sv
// ---------------------------------------------------------------------------
// w_serializer
// Parallel-to-serial front end for the ej3b sequence detector. A WIDTH-bit
// word accepted through load/ready is driven MSB first on w, one bit per
// rising edge of clk, with back-to-back words streaming without a gap.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit (XOR of
// the whole word) after the last data bit; the word then takes WIDTH+1 cycles.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset
//   din    - word to serialize, sampled only on an accepted load
//   load   - load request, accepted on an edge where load && ready
//   ready  - a word can be accepted on the next edge
//   w      - serial bit to the detector (registered)
//   valid  - w carries a data or parity bit this cycle (registered)
//   done   - high during the final serial bit of the current word
// ---------------------------------------------------------------------------
module w_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH      = SER_WIDTH_DEFAULT,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             w,
    output logic             valid,
    output logic             done
);

    ser_state_t       state;
    logic [WIDTH-1:0] shreg;
    logic             term;
    logic             accept;
    logic             cntInc;
`ifdef SER_PARITY_EN
    logic             parityBit;
`endif

    // ready and done are decoded purely from registered state and count, so
    // they change only right after a clock edge. With parity the last data
    // bit is not the final serial bit, so the handshake moves to PARITY.
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
`ifdef SER_PARITY_EN
                ready = 1'b0;
                done  = 1'b0;
`else
                ready = term;
                done  = term;
`endif
            end
            PARITY: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    assign accept = load && ready;
    assign cntInc = (state == SHIFT) && !accept;

    ser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .inc   (cntInc),
        .term  (term)
    );

    // w is registered, so on an accepted load the MSB goes straight onto the
    // line and shreg keeps only the bits still to come, MSB-aligned. An accept
    // always takes priority, which is what gives gap-free streaming when load
    // is held through the final bit of the previous word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            w     <= IDLE_LEVEL;
            valid <= 1'b0;
`ifdef SER_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else if (accept) begin
            state <= SHIFT;
            shreg <= {din[WIDTH-2:0], 1'b0};
            w     <= din[WIDTH-1];
            valid <= 1'b1;
`ifdef SER_PARITY_EN
            parityBit <= ^din;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (!term) begin
                        w     <= shreg[WIDTH-1];
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                    end else begin
`ifdef SER_PARITY_EN
                        state <= PARITY;
                        w     <= parityBit;
                        valid <= 1'b1;
`else
                        state <= IDLE;
                        w     <= IDLE_LEVEL;
                        valid <= 1'b0;
`endif
                    end
                end
                PARITY: begin
                    state <= IDLE;
                    w     <= IDLE_LEVEL;
                    valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    w     <= IDLE_LEVEL;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_w_serializer.sv
// ---------------------------------------------------------------------------
// tb_w_serializer
// Self-checking bench for w_serializer (WIDTH = 8, IDLE_LEVEL = 0). A
// reference model tracks how many serial cycles of the current word remain
// and expands every accepted word into its expected bit list, which a monitor
// consumes whenever the DUT shows valid. Honours SER_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_w_serializer;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;
`ifdef SER_PARITY_EN
    localparam bit   PAR  = 1'b1;
`else
    localparam bit   PAR  = 1'b0;
`endif
    localparam int   WORD_CYC = W + (PAR ? 1 : 0);

    typedef struct packed {
        logic bitVal;
        logic last;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] din;
    logic         load;
    logic         ready;
    logic         w;
    logic         valid;
    logic         done;

    exp_t expQ[$];
    int   modelLeft;
    int   checks;
    int   errors;

    w_serializer #(
        .WIDTH      (W),
        .IDLE_LEVEL (IDLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .load  (load),
        .ready (ready),
        .w     (w),
        .valid (valid),
        .done  (done)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison: counts it and reports a mismatch.
    task automatic compareBit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s actual=%0b expected=%0b t=%0t", name, act, expv, $time);
        end
    endtask

    // Expand a word into its serial bit list: MSB first, then optional parity
    // bit (1 when the word holds an odd number of ones).
    task automatic pushWord(input logic [W-1:0] d);
        exp_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.bitVal = d[i];
            e.last   = (i == 0) && !PAR;
            expQ.push_back(e);
        end
        if (PAR) begin
            e.bitVal = ($countones(d) % 2) == 1;
            e.last   = 1'b1;
            expQ.push_back(e);
        end
    endtask

    // Reference model: a word occupies WORD_CYC cycles; a new one is taken
    // whenever at most the final cycle of the previous one remains.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modelLeft <= 0;
            expQ.delete();
        end else if (load && (modelLeft <= 1)) begin
            pushWord(din);
            modelLeft <= WORD_CYC;
        end else if (modelLeft > 0) begin
            modelLeft <= modelLeft - 1;
        end
    end

    // Handshake and idle-level checks against the model every cycle.
    task automatic checkOutput();
        compareBit("valid", valid, modelLeft > 0);
        compareBit("ready", ready, modelLeft <= 1);
        compareBit("done", done, modelLeft == 1);
        if (modelLeft == 0) compareBit("idle_w", w, IDLE);
    endtask

    always @(negedge clk) begin
        checkOutput();
    end

    // Scoreboard monitor: every valid serial bit must match the next expected.
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected actual=valid expected=no_data t=%0t", $time);
            end else begin
                e = expQ.pop_front();
                compareBit("sb_w", w, e.bitVal);
                compareBit("sb_done", done, e.last);
            end
        end
    end

    // Offer a word and hold load until it is taken; returns at the negedge
    // after the accepting edge with load still high.
    task automatic applyStimulus(input logic [W-1:0] d);
        bit sawReady;
        bit accepted;
        accepted = 1'b0;
        din  = d;
        load = 1'b1;
        for (int n = 0; n < 40; n++) begin
            sawReady = ready;
            @(posedge clk);
            @(negedge clk);
            if (sawReady) begin
                accepted = 1'b1;
                break;
            end
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL load_timeout actual=not_accepted expected=accepted word=%h", d);
        end
    endtask

    task automatic idleCycles(input int n);
        load = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        load   = 1'b0;
        din    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] idle stability");
        idleCycles(20);

        $display("[TB] single word");
        applyStimulus(8'b1001_1011);
        idleCycles(12);

        $display("[TB] back-to-back streaming");
        applyStimulus(8'hA5);
        applyStimulus(8'h0F);
        idleCycles(12);

        $display("[TB] load while busy");
        applyStimulus(8'h81);
        load = 1'b0;
        repeat (3) @(negedge clk);
        din  = 8'hFF;
        load = 1'b1;
        compareBit("busy_ready", ready, 1'b0);
        @(negedge clk);
        idleCycles(12);

        $display("[TB] reset mid-word");
        applyStimulus(8'hC3);
        load = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        compareBit("rst_w", w, IDLE);
        compareBit("rst_valid", valid, 1'b0);
        compareBit("rst_ready", ready, 1'b1);
        compareBit("rst_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'h01);
        idleCycles(12);

        $display("[TB] parity pattern words");
        applyStimulus(8'b1001_1011);
        applyStimulus(8'h03);
        idleCycles(12);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                load = 1'b0;
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            din  = W'($urandom);
            load = ($urandom_range(0, 9) < 6);
            @(negedge clk);
        end
        idleCycles(15);

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain actual=%0d expected=0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w_serializer.md
# w_serializer

Parallel-to-serial front end for the `ej3b` sequence-detector stage. It accepts a WIDTH-bit word through a load/ready handshake and drives it onto the single-bit `w` line, one bit per `clk` rising edge, MSB first. The detector samples `w` on the same clock, so a word loaded here appears as a directed bit stream at the detector input. Back-to-back words stream with no idle gap.

## Interface

- `WIDTH`, default 8: word length in bits. Must be at least 2.
- `IDLE_LEVEL`, default 1'b0: level driven on `w` while no bit is being shifted.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `din`, input, WIDTH: word to serialize. Sampled only on an accepted load.
- `load`, input, 1: load request. Accepted on a rising edge when `load && ready`.
- `ready`, output, 1: the block can accept a word on the next edge.
- `w`, output, 1: serial bit to the detector.
- `valid`, output, 1: `w` carries a data bit (or the parity bit) this cycle.
- `done`, output, 1: high during the final serial bit of the current word.

## Operation

- **States:** IDLE, SHIFT, PARITY. The PARITY state exists only with `SER_PARITY_EN`.
- **Reset values:**
  - State goes to IDLE and the bit counter to 0.
  - The shift register clears to 0.
  - Outputs: `w` = IDLE_LEVEL, `valid` = 0, `done` = 0, `ready` = 1.
- **IDLE:**
  - `valid` = 0, `w` = IDLE_LEVEL, `ready` = 1.
  - `load` accepted: capture `din` into the shift register, clear the counter, go to SHIFT.
- **SHIFT:**
  - `w` = `shreg[WIDTH-1]`, `valid` = 1.
  - Each edge shifts the register left by one and increments the counter.
  - When the counter reaches WIDTH-1, the current cycle is the last data bit.
- **Last data bit, `SER_PARITY_EN` off:**
  - `done` = 1 and `ready` = 1.
  - If `load` is high, the new word is captured and SHIFT restarts at count 0 with no gap.
  - Otherwise go to IDLE.
- **Last data bit, `SER_PARITY_EN` on:**
  - `ready` = 0 and `done` = 0.
  - Next state is PARITY.
- **PARITY:**
  - `w` = even parity (XOR of all WIDTH bits of the captured word), `valid` = 1, `done` = 1, `ready` = 1.
  - Load and next-state handling are the same as the last-data-bit case with parity off.
- **Load while busy:**
  - `load` while `ready` = 0 is ignored: no capture and no error.
  - The requester holds `load` until it sees `ready`.
- **Counter width:** $clog2(WIDTH). The counter never wraps past WIDTH-1.
- **Output registration:**
  - `w` and `valid` are registered outputs.
  - `ready` and `done` are decoded from the state and counter.
  - All outputs are glitch-free relative to `clk`.

## Timing

- **Load latency:**
  - A load is accepted on edge k.
  - The MSB is valid on `w` from edge k to edge k+1.
  - Bit i (counted from the MSB) is valid from edge k+i to edge k+i+1.
- **Word length on the line:** WIDTH cycles, or WIDTH+1 cycles with parity.
- **Streaming throughput:**
  - One word every WIDTH cycles, or WIDTH+1 with parity, when `load` is held high.
  - `valid` stays at 1 continuously during streaming.
- **Asynchronous reset:**
  - `reset` asserted at any time, including mid-word, forces the reset values immediately, without waiting for `clk`.
  - The partially shifted word is discarded.
- **First load after reset:** the first edge after reset deasserts may accept a load.
- **Load coincident with reset:** lost.

## Configuration

- **Macro:** `SER_PARITY_EN`.
- **Defined:**
  - The PARITY state and the parity XOR are compiled in.
  - Each word occupies WIDTH+1 cycles on `w`.
  - `done` and `ready` assert in the parity cycle.
- **Undefined:**
  - No PARITY state and no parity logic.
  - Each word occupies WIDTH cycles.
  - `done` and `ready` assert in the last data-bit cycle.

## Structure

- **Package `ser_pkg`:**
  - State enum `ser_state_t` {IDLE, SHIFT, PARITY}.
  - Constant `SER_WIDTH_DEFAULT` = 8.
  - A function for the counter width.
- **Sub-module `ser_bit_counter`:**
  - Loadable up-counter.
  - Inputs: `clear`, `inc`.
  - Output: terminal flag at WIDTH-1.
  - Same clock and reset as the parent.
- **Top level:** the FSM, shift register and optional parity live in `w_serializer`.

## Test plan

All scenarios use WIDTH = 8 and IDLE_LEVEL = 0.

- **Single word, parity off:** reset, then `din` = 8'b1001_1011 with `load` for 1 cycle.
  - `w` = 1,0,0,1,1,0,1,1 on consecutive edges, `valid` = 1 throughout.
  - `done` high only in the 8th bit cycle; then `w` = 0, `valid` = 0, `ready` = 1.
- **Back-to-back streaming:** `load` held with 8'hA5 then 8'h0F.
  - 16 consecutive `valid` cycles carrying 10100101 00001111.
  - `ready` high at cycles 8 and 16 only.
- **Load while busy:** pulse `load` with 8'hFF during bit 3 of word 8'h81.
  - Output stays 10000001, 8'hFF never appears, and `ready` = 0 during the pulse.
- **Reset mid-word:** assert `reset` between edges during bit 4 of 8'hC3.
  - `w` = 0, `valid` = 0, `ready` = 1 immediately, before the next edge.
  - After release, a new load of 8'h01 serializes cleanly.
- **Parity build (`SER_PARITY_EN`):** 8'b1001_1011 (five ones).
  - 9 valid bits, with the 9th = 1.
  - 8'h03 gives 9th bit = 0; `done` only in the 9th cycle.
- **Idle stability:** 20 cycles with no load after reset.
  - `w` = 0, `valid` = 0, `done` = 0, `ready` = 1 throughout.
